// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and default baud divisor
// used by both the transmitter and the receiver.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 50 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_if.sv
// First-word-fall-through FIFO read port between a word source and the UART transmitter.
interface uart_tx_if #(
  parameter int W = 8
);
  logic [W-1:0] fifo_data;
  logic         fifo_empty;
  logic         fifo_pop;

  modport master (output fifo_data, output fifo_empty, input fifo_pop);
  modport slave  (input fifo_data, input fifo_empty, output fifo_pop);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a FWFT FIFO and sends 8N1-style frames, LSB first.
//
// state | meaning
// IDLE  | line high; pops and latches the FIFO head when it is non-empty
// START | start bit (low) for one bit period
// DATA  | W data bits, LSB first, bit_idx = 0..W-1
// STOP  | line high for STOP_BITS bit periods, bit_idx counts stop bits
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int W            = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   fifo,
  output logic       tx,
  output logic       busy
);
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  uart_state_e      state;
  logic [W-1:0]     shreg;
  logic [IDX_W-1:0] bit_idx;
  logic             pop;
  logic             baud_clear;
  logic             baud_tick;

  // Pop is combinational so the strobe lands in the same cycle the head word is latched.
  assign pop           = (state == IDLE) && !fifo.fifo_empty && !reset;
  assign fifo.fifo_pop = pop;
  assign busy          = (state != IDLE) || pop;
  assign baud_clear    = (state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= fifo.fifo_data;
            tx      <= 1'b0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx == IDX_W'(W - 1)) begin
              tx      <= 1'b1;
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: two instances (1 and 2 stop bits) checked cycle by cycle against a frame-level model.
module tb_uart_tx;
  localparam int W   = 8;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx0, busy0, tx1, busy1;

  uart_tx_if #(.W(W)) if0 ();
  uart_tx_if #(.W(W)) if1 ();

  uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk (clk), .reset (reset), .fifo (if0.slave), .tx (tx0), .busy (busy0)
  );
  uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .clk (clk), .reset (reset), .fifo (if1.slave), .tx (tx1), .busy (busy1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: FIFO contents, forced-empty flag, and position k within the current frame.
  logic [W-1:0] q[2][$];
  bit           fe[2];
  bit           fa[2];
  int           k[2];
  logic [W-1:0] wrd[2];
  int           nstop[2] = '{1, 2};
  int           cyc = 0;
  int           dut_last[2] = '{0, 0};
  int           dut_gap[2]  = '{0, 0};
  int           dut_pops[2] = '{0, 0};

  // Line level at k cycles after the pop cycle: start bit, W data bits LSB first, then stop.
  function automatic logic frame_bit(input logic [W-1:0] d, input int kk);
    int b;
    b = (kk - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    return 1'b1;
  endfunction

  task automatic step();
    logic         emp[2];
    logic [W-1:0] dat[2];
    logic         o_pop, o_tx, o_busy, e_pop, e_tx, e_busy;
    for (int d = 0; d < 2; d++) begin
      emp[d] = (q[d].size() == 0) || fe[d];
      dat[d] = emp[d] ? W'($urandom) : q[d][0];
    end
    if0.fifo_empty = emp[0]; if0.fifo_data = dat[0];
    if1.fifo_empty = emp[1]; if1.fifo_data = dat[1];
    #1;
    for (int d = 0; d < 2; d++) begin
      o_pop  = (d == 0) ? if0.fifo_pop : if1.fifo_pop;
      o_tx   = (d == 0) ? tx0 : tx1;
      o_busy = (d == 0) ? busy0 : busy1;
      e_pop  = !reset && !emp[d] && !fa[d];
      e_tx   = fa[d] ? frame_bit(wrd[d], k[d]) : 1'b1;
      e_busy = fa[d] || e_pop;
      chk((d == 0) ? "pop0" : "pop1", 32'(o_pop), 32'(e_pop));
      chk((d == 0) ? "tx0" : "tx1", 32'(o_tx), 32'(e_tx));
      chk((d == 0) ? "busy0" : "busy1", 32'(o_busy), 32'(e_busy));
      if (o_pop === 1'b1) begin
        dut_gap[d]  = cyc - dut_last[d];
        dut_last[d] = cyc;
        dut_pops[d]++;
      end
      if (reset) begin
        fa[d] = 1'b0;
      end else if (e_pop) begin
        fa[d]  = 1'b1;
        k[d]   = 1;
        wrd[d] = q[d].pop_front();
      end else if (fa[d]) begin
        k[d]++;
        if (k[d] > (1 + W + nstop[d]) * CPB) fa[d] = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pops(input int d, input int target, input int budget);
    int i;
    i = 0;
    while (dut_pops[d] < target && i < budget) begin
      step();
      i++;
    end
    if (dut_pops[d] < target) chk("pop_timeout", 32'(dut_pops[d]), 32'(target));
  endtask

  initial begin
    int p;
    reset = 1'b1;
    q[0].push_back(8'hA5);
    if0.fifo_empty = 1'b0; if0.fifo_data = 8'hA5;
    if1.fifo_empty = 1'b1; if1.fifo_data = '0;
    @(negedge clk);
    // reset held with a non-empty FIFO: no pop, line idle
    run(4);
    reset = 1'b0;

    // single frame 0xA5
    wait_pops(0, 1, 20);
    run(45);
    chk("a5_tx_idle", 32'(tx0), 32'(1'b1));
    chk("a5_busy_low", 32'(busy0), 32'(1'b0));

    // back-to-back 0x00, 0xFF
    p = dut_pops[0];
    q[0].push_back(8'h00);
    q[0].push_back(8'hFF);
    wait_pops(0, p + 2, 200);
    chk("gap_1stop", 32'(dut_gap[0]), 32'd41);
    run(45);

    // long empty stretch
    run(200);

    // reset during data bit 3 of 0x3C; following word must be sent instead
    p = dut_pops[0];
    q[0].push_back(8'h3C);
    q[0].push_back(8'h5A);
    wait_pops(0, p + 1, 20);
    run(17);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_tx_high", 32'(tx0), 32'(1'b1));
    wait_pops(0, p + 2, 20);
    run(45);

    // input churn mid-frame of 0x81
    p = dut_pops[0];
    q[0].push_back(8'h81);
    q[0].push_back(8'h7E);
    wait_pops(0, p + 1, 20);
    for (int i = 0; i < 38; i++) begin
      fe[0] = 1'($urandom_range(0, 1));
      step();
    end
    fe[0] = 1'b0;
    wait_pops(0, p + 2, 20);
    chk("churn_gap", 32'(dut_gap[0]), 32'd41);
    run(45);

    // two stop bits, 0x55
    p = dut_pops[1];
    q[1].push_back(8'h55);
    q[1].push_back(8'h55);
    wait_pops(1, p + 2, 200);
    chk("gap_2stop", 32'(dut_gap[1]), 32'd45);
    run(50);

    // random traffic on both instances
    for (int i = 0; i < 20; i++) begin
      q[0].push_back(W'($urandom));
      q[1].push_back(W'($urandom));
    end
    for (int i = 0; i < 1400; i++) begin
      fe[0] = ($urandom_range(0, 15) == 0);
      fe[1] = ($urandom_range(0, 15) == 0);
      step();
    end
    fe[0] = 1'b0;
    fe[1] = 1'b0;
    run(120);
    chk("q0_drained", 32'(q[0].size()), 32'd0);
    chk("q1_drained", 32'(q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter W, default 8: data bits per frame, equal to the FIFO word width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud): clk cycles per serial bit; legal range >= 2.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port fifo_data  input  W: head word of the upstream FIFO, first-word-fall-through, valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_empty  input  1: upstream FIFO empty flag.
REQ-008 SHALL have port fifo_pop  output  1: single-cycle pop strobe, driven to the FIFO do_pop.
REQ-009 SHALL have port tx  output  1: serial line, registered, idle high.
REQ-010 SHALL have port busy  output  1: high from the pop cycle through the last stop-bit cycle.

Function
REQ-011 SHALL implement the states IDLE, START, DATA and STOP, held in one registered state variable.
REQ-012 In IDLE with fifo_empty=0, the block SHALL load fifo_data into a W-bit shift register, assert fifo_pop for exactly that one cycle, and move to START.
REQ-013 SHALL never assert fifo_pop while fifo_empty=1, and never in any state other than IDLE.
REQ-014 tx SHALL go low on the clock edge after the pop cycle and stay low for exactly CLKS_PER_BIT cycles (START).
REQ-015 DATA SHALL send W bits LSB first, each held exactly CLKS_PER_BIT cycles, using a bit index counter that runs 0..W-1.
REQ-016 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles and then return to IDLE.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1, restart at 0 on every state entry, and be sized $clog2(CLKS_PER_BIT) bits with no overflow.
REQ-018 With the FIFO continuously non-empty, frame period SHALL be exactly 1+(1+W+STOP_BITS)*CLKS_PER_BIT cycles, including one idle-high gap cycle (the pop cycle).
REQ-019 Changes on fifo_empty or fifo_data during START/DATA/STOP SHALL have no effect on the current frame; the latched word is the only data source.
REQ-020 busy SHALL be combinationally (state != IDLE) OR fifo_pop.

Reset
REQ-021 On reset=1 at a clock edge: state=IDLE, tx=1, fifo_pop=0, busy=0, counters=0, shift register=0.
REQ-022 Reset mid-frame SHALL abort the frame: tx=1 from the next edge; the popped word is discarded and not re-sent.
REQ-023 While reset=1, fifo_pop SHALL remain 0 even if fifo_empty=0.

Structure
REQ-024 State encodings (IDLE=0, START=1, DATA=2, STOP=3) and the default baud constant SHALL live in the shared UART definitions header used by the rx and tx blocks.
REQ-025 The baud counter SHALL be a sub-module uart_baud_cnt (inputs clk, reset, clear; output tick at count CLKS_PER_BIT-1), reusable by the receiver.
REQ-026 Target size: 120-250 lines RTL including the sub-module.

Verification (CLKS_PER_BIT=4, W=8, STOP_BITS=1 unless stated)
REQ-027 FIFO holds 0xA5 -> one fifo_pop pulse; tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; then tx=1, busy=0.
REQ-028 FIFO holds 0x00, 0xFF back-to-back -> two pops exactly 41 cycles apart; tx of frame 2 = 0,1x8,1.
REQ-029 fifo_empty=1 for 200 cycles -> tx=1, fifo_pop=0, busy=0 throughout.
REQ-030 reset pulsed during DATA bit 3 of 0x3C -> tx=1 on the next edge, state IDLE; the next pop transmits the following FIFO word, not 0x3C.
REQ-031 fifo_data toggled and fifo_empty forced 1 mid-frame of 0x81 -> serial bits still 0x81; no pop until STOP ends.
REQ-032 STOP_BITS=2, word 0x55 -> stop phase lasts 8 cycles; pop period 45 cycles.
